tick_divider_prog: RTL and testbench
====================================

// Module: tick_divider_prog
// PURPOSE
//  Programmable clock-enable generator for the microwave timer path: divides clk by a
//  run-time loadable divisor and emits a one-cycle tick per period.
//  Supports pause (door open / stop), synchronous clear, and live divisor reload.
//  Feeds the seconds/display counters as a clock enable; the result is never used as a clock.
// PARAMETERS
//  WIDTH        16   width of counter, divisor input and divisor register
//  DIV_DEFAULT  100  divisor after reset; legal range 1..2**WIDTH-1
// PORTS
//  clk       in   1      system clock; all logic on posedge
//  rst       in   1      synchronous reset, active-high
//  en        in   1      count enable; 0 = pause (count held)
//  clr       in   1      synchronous clear of the count phase
//  load      in   1      strobe: latch div_in as the new divisor
//  div_in    in   WIDTH  divisor value sampled when load=1
//  tick      out  1      one-cycle pulse, once per divisor cycles of enabled clk
//  count     out  WIDTH  current phase counter, 0..div_q-1
//  div_q     out  WIDTH  divisor in effect
//  load_err  out  1      sticky: a load with div_in==0 was rejected
//  sq_out    out  1      square wave, period 2*div_q ticks-domain (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst=1 on an edge): count=0, div_q=DIV_DEFAULT, tick=0, load_err=0, sq_out=0.
//  - Priority per edge: rst > clr/load > en counting. All outputs are registered.
//  - Counting (en=1, no clr/load):
//      count != div_q-1 -> count+1, tick<=0
//      count == div_q-1 -> count<=0, tick<=1
//    tick is high during the cycle in which count reads 0 (one cycle after terminal).
//    Period = div_q enabled cycles.
//  - div_q==1: terminal every cycle; tick stays high while en=1.
//  - Pause (en=0): count holds; tick<=0. On resume, the phase continues where it stopped,
//    with no extra or lost tick.
//  - clr=1: count<=0, tick<=0, regardless of en. div_q is unchanged.
//  - load=1, div_in!=0: div_q<=div_in, count<=0, tick<=0. The next tick comes after
//    div_in enabled cycles.
//  - load=1, div_in==0: div_q unchanged, count/tick continue per normal rules,
//    load_err<=1. load_err is cleared only by rst.
//  - clr and load in the same cycle: both take effect (new div_q, count=0, tick=0).
//  - Terminal count coinciding with clr/load: clr/load wins; no tick is produced.
//  - No wrap beyond div_q-1. Comparison is exact at WIDTH bits; count never exceeds
//    2**WIDTH-2.
// CONFIGURATION
//  TICK_DIV_SQUARE_EN defined:
//    sq_out toggles on each cycle where tick is set, i.e. sq_out <= ~sq_out in the same
//    edge that sets tick<=1.
//    clr, load and rst force sq_out<=0.
//    Held during pause.
//  TICK_DIV_SQUARE_EN undefined: sq_out tied to 0; no toggle flop is instantiated.
// STRUCTURE
//  Shared package tick_div_pkg: WIDTH default constant, DIV_DEFAULT constant,
//  typedef div_t (logic [WIDTH-1:0]).
//  Flat module, no sub-module. The counter, divisor register and error flag are three
//  always blocks in one file.
// TESTING
//  1 rst, then en=1 for 300 cycles at DIV_DEFAULT=100 -> tick on exactly 3 cycles,
//    100 apart; count cycles 0..99.
//  2 en=1 to count=40, en=0 for 25 cycles, en=1 -> count frozen at 40 during the pause;
//    the next tick arrives 60 enabled cycles after resume.
//  3 count=70, load=1 with div_in=10 -> div_q=10, count=0, no tick; ticks then every
//    10 cycles.
//  4 load=1 with div_in=0 at count=5 -> div_q stays 100, load_err=1 until rst,
//    count continues to 6.
//  5 clr and load (div_in=4) together with count==div_q-1 -> no tick, count=0, div_q=4;
//    load=1 div_in=1 -> tick held high.
//  6 With TICK_DIV_SQUARE_EN and div=5 -> sq_out toggles every 5 cycles (period 10);
//    rst mid-run -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/tick_div_pkg.sv
// Shared constants and types for the programmable tick divider.
package tick_div_pkg;

  localparam int TICK_WIDTH       = 16;
  localparam int TICK_DIV_DEFAULT = 100;

  typedef logic [TICK_WIDTH-1:0] div_t;

endpackage

// File: rtl/tick_divider_prog.sv
// Programmable clock-enable generator: one-cycle tick every div_q enabled cycles.
// Optional square-wave output is built only when TICK_DIV_SQUARE_EN is defined.
module tick_divider_prog
  import tick_div_pkg::*;
#(
  parameter int WIDTH       = TICK_WIDTH,
  parameter int DIV_DEFAULT = TICK_DIV_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] div_in,
  output logic             tick,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] div_q,
  output logic             load_err,
  output logic             sq_out
);

  logic load_ok;
  logic load_bad;
  logic terminal;
  logic restart;

  // A zero divisor is rejected, so only a nonzero load restarts the phase.
  assign load_ok  = load && (div_in != '0);
  assign load_bad = load && (div_in == '0);
  assign restart  = clr || load_ok;
  assign terminal = (count == (div_q - WIDTH'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (restart) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (en) begin
      if (terminal) begin
        count <= '0;
        tick  <= 1'b1;
      end else begin
        count <= count + WIDTH'(1);
        tick  <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= WIDTH'(DIV_DEFAULT);
    end else if (load_ok) begin
      div_q <= div_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_err <= 1'b0;
    end else if (load_bad) begin
      load_err <= 1'b1;
    end
  end

`ifdef TICK_DIV_SQUARE_EN
  // Toggles on the same edge that raises tick, giving a period of 2*div_q.
  logic sq_q;

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      sq_q <= 1'b0;
    end else if (en && terminal) begin
      sq_q <= ~sq_q;
    end
  end

  assign sq_out = sq_q;
`else
  assign sq_out = 1'b0;
`endif

endmodule

// File: tb/tb_tick_divider_prog.sv
// Self-checking bench for tick_divider_prog; square-wave checks follow TICK_DIV_SQUARE_EN.
module tb_tick_divider_prog;

  localparam int W   = 16;
  localparam int DEF = 100;
  localparam int EW  = 1 + W + W + 1 + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         clr = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] div_in = '0;
  logic         tick;
  logic [W-1:0] count;
  logic [W-1:0] div_q;
  logic         load_err;
  logic         sq_out;

  tick_divider_prog #(.WIDTH(W), .DIV_DEFAULT(DEF)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .div_in(div_in),
    .tick(tick), .count(count), .div_q(div_q), .load_err(load_err), .sq_out(sq_out)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_v;
  logic [EW-1:0] obs_v;

  // Reference model state, advanced when stimulus is driven.
  logic         m_tick = 1'b0;
  logic [W-1:0] m_count = '0;
  logic [W-1:0] m_div = W'(DEF);
  logic         m_err = 1'b0;
  logic         m_sq = 1'b0;

  task automatic drive(input logic r, input logic e, input logic c, input logic l,
                       input logic [W-1:0] d);
    logic ok;
    rst = r; en = e; clr = c; load = l; div_in = d;
    ok = l && (d != '0);
    if (r) begin
      m_count = '0; m_tick = 1'b0; m_div = W'(DEF); m_err = 1'b0; m_sq = 1'b0;
    end else begin
      if (l && d == '0) m_err = 1'b1;
      if (c || ok) begin
        m_count = '0; m_tick = 1'b0; m_sq = 1'b0;
        if (ok) m_div = d;
      end else if (e) begin
        if (m_count == m_div - W'(1)) begin
          m_count = '0; m_tick = 1'b1; m_sq = ~m_sq;
        end else begin
          m_count = m_count + W'(1); m_tick = 1'b0;
        end
      end else begin
        m_tick = 1'b0;
      end
    end
`ifndef TICK_DIV_SQUARE_EN
    m_sq = 1'b0;
`endif
    exp_q.push_back({m_tick, m_count, m_div, m_err, m_sq});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    exp_v = exp_q.pop_front(); obs_v = {tick, count, div_q, load_err, sq_out}; vectors++;
    if (obs_v !== exp_v) begin
      miscompares++; $display("FAIL reset_sb got=%h want=%h", obs_v, exp_v);
    end
    vectors++;
    if (count !== '0 || div_q !== W'(DEF) || tick !== 1'b0 || load_err !== 1'b0 || sq_out !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_vals got count=%0d div=%0d tick=%b err=%b sq=%b want 0/%0d/0/0/0",
               count, div_q, tick, load_err, sq_out, DEF);
    end
  endtask

  task automatic test_count();
    int ticks = 0;
    int pos[$];
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    void'(exp_q.pop_front());
    for (int i = 1; i <= 300; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
      exp_v = exp_q.pop_front(); obs_v = {tick, count, div_q, load_err, sq_out}; vectors++;
      if (obs_v !== exp_v) begin
        miscompares++; $display("FAIL count_sb cyc=%0d got=%h want=%h", i, obs_v, exp_v);
      end
      if (tick === 1'b1) begin ticks++; pos.push_back(i); end
    end
    vectors++;
    if (ticks != 3) begin
      miscompares++; $display("FAIL count_ticks got=%0d want=3", ticks);
    end
    for (int k = 0; k < pos.size(); k++) begin
      vectors++;
      if (pos[k] != 100 * (k + 1)) begin
        miscompares++; $display("FAIL count_tick_pos k=%0d got=%0d want=%0d", k, pos[k], 100 * (k + 1));
      end
    end
  endtask

  task automatic test_pause();
    int first = -1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
      void'(exp_q.pop_front());
    end
    for (int i = 0; i < 25; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
      exp_v = exp_q.pop_front(); obs_v = {tick, count, div_q, load_err, sq_out}; vectors++;
      if (obs_v !== exp_v || count !== W'(40) || tick !== 1'b0) begin
        miscompares++; $display("FAIL pause_hold cyc=%0d got count=%0d tick=%b want 40/0", i, count, tick);
      end
    end
    for (int i = 1; i <= 100; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
      exp_v = exp_q.pop_front(); obs_v = {tick, count, div_q, load_err, sq_out}; vectors++;
      if (obs_v !== exp_v) begin
        miscompares++; $display("FAIL pause_resume_sb cyc=%0d got=%h want=%h", i, obs_v, exp_v);
      end
      if (tick === 1'b1 && first < 0) first = i;
    end
    vectors++;
    if (first != 60) begin
      miscompares++; $display("FAIL pause_next_tick got=%0d want=60", first);
    end
  endtask

  task automatic test_load();
    int ticks = 0;
    int first = -1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 70; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
      void'(exp_q.pop_front());
    end
    drive(1'b0, 1'b1, 1'b0, 1'b1, W'(10));
    exp_v = exp_q.pop_front(); obs_v = {tick, count, div_q, load_err, sq_out}; vectors++;
    if (obs_v !== exp_v || div_q !== W'(10) || count !== '0 || tick !== 1'b0) begin
      miscompares++; $display("FAIL load_apply got div=%0d count=%0d tick=%b want 10/0/0", div_q, count, tick);
    end
    for (int i = 1; i <= 30; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
      exp_v = exp_q.pop_front(); obs_v = {tick, count, div_q, load_err, sq_out}; vectors++;
      if (obs_v !== exp_v) begin
        miscompares++; $display("FAIL load_run_sb cyc=%0d got=%h want=%h", i, obs_v, exp_v);
      end
      if (tick === 1'b1) begin ticks++; if (first < 0) first = i; end
    end
    vectors++;
    if (ticks != 3 || first != 10) begin
      miscompares++; $display("FAIL load_ticks got=%0d first=%0d want 3 first=10", ticks, first);
    end
  endtask

  task automatic test_load_zero();
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
      void'(exp_q.pop_front());
    end
    drive(1'b0, 1'b1, 1'b0, 1'b1, '0);
    exp_v = exp_q.pop_front(); obs_v = {tick, count, div_q, load_err, sq_out}; vectors++;
    if (obs_v !== exp_v || count !== W'(6) || div_q !== W'(DEF) || load_err !== 1'b1) begin
      miscompares++;
      $display("FAIL load_zero got count=%0d div=%0d err=%b want 6/%0d/1", count, div_q, load_err, DEF);
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
      exp_v = exp_q.pop_front(); obs_v = {tick, count, div_q, load_err, sq_out}; vectors++;
      if (obs_v !== exp_v || load_err !== 1'b1) begin
        miscompares++; $display("FAIL load_err_sticky cyc=%0d got err=%b want 1", i, load_err);
      end
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
    exp_v = exp_q.pop_front(); obs_v = {tick, count, div_q, load_err, sq_out}; vectors++;
    if (obs_v !== exp_v || load_err !== 1'b0) begin
      miscompares++; $display("FAIL load_err_rst got err=%b want 0", load_err);
    end
  endtask

  task automatic test_clr_load();
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 99; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
      void'(exp_q.pop_front());
    end
    drive(1'b0, 1'b1, 1'b1, 1'b1, W'(4));
    exp_v = exp_q.pop_front(); obs_v = {tick, count, div_q, load_err, sq_out}; vectors++;
    if (obs_v !== exp_v || tick !== 1'b0 || count !== '0 || div_q !== W'(4)) begin
      miscompares++; $display("FAIL clr_load_term got tick=%b count=%0d div=%0d want 0/0/4", tick, count, div_q);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
      void'(exp_q.pop_front());
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0, '0);
    exp_v = exp_q.pop_front(); obs_v = {tick, count, div_q, load_err, sq_out}; vectors++;
    if (obs_v !== exp_v || count !== '0 || tick !== 1'b0 || div_q !== W'(4)) begin
      miscompares++; $display("FAIL clr_term got tick=%b count=%0d div=%0d want 0/0/4", tick, count, div_q);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b1, W'(1));
    void'(exp_q.pop_front());
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
      exp_v = exp_q.pop_front(); obs_v = {tick, count, div_q, load_err, sq_out}; vectors++;
      if (obs_v !== exp_v || tick !== 1'b1 || count !== '0) begin
        miscompares++; $display("FAIL div1_tick_high cyc=%0d got tick=%b count=%0d want 1/0", i, tick, count);
      end
    end
  endtask

  task automatic test_square_and_rst();
    int toggles = 0;
    int want_toggles;
    logic prev;
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    void'(exp_q.pop_front());
    drive(1'b0, 1'b1, 1'b0, 1'b1, W'(5));
    void'(exp_q.pop_front());
    prev = sq_out;
    for (int i = 1; i <= 30; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
      exp_v = exp_q.pop_front(); obs_v = {tick, count, div_q, load_err, sq_out}; vectors++;
      if (obs_v !== exp_v) begin
        miscompares++; $display("FAIL square_sb cyc=%0d got=%h want=%h", i, obs_v, exp_v);
      end
      if (sq_out !== prev) toggles++;
      prev = sq_out;
    end
`ifdef TICK_DIV_SQUARE_EN
    want_toggles = 6;
`else
    want_toggles = 0;
`endif
    vectors++;
    if (toggles != want_toggles) begin
      miscompares++; $display("FAIL square_toggles got=%0d want=%0d", toggles, want_toggles);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b1, '0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
      void'(exp_q.pop_front());
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1, W'(9));
    exp_v = exp_q.pop_front(); obs_v = {tick, count, div_q, load_err, sq_out}; vectors++;
    if (obs_v !== exp_v || tick !== 1'b0 || count !== '0 || div_q !== W'(DEF) ||
        load_err !== 1'b0 || sq_out !== 1'b0) begin
      miscompares++;
      $display("FAIL midrun_rst got tick=%b count=%0d div=%0d err=%b sq=%b want 0/0/%0d/0/0",
               tick, count, div_q, load_err, sq_out, DEF);
    end
  endtask

  task automatic test_random();
    logic e, c, l, r;
    logic [W-1:0] d;
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 400; i++) begin
      e = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 29) == 0);
      l = ($urandom_range(0, 19) == 0);
      r = ($urandom_range(0, 149) == 0);
      d = W'($urandom_range(0, 8));
      drive(r, e, c, l, d);
      exp_v = exp_q.pop_front(); obs_v = {tick, count, div_q, load_err, sq_out}; vectors++;
      if (obs_v !== exp_v) begin
        miscompares++; $display("FAIL random_sb cyc=%0d got=%h want=%h", i, obs_v, exp_v);
      end
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_count();
    test_pause();
    test_load();
    test_load_zero();
    test_clr_load();
    test_square_and_rst();
    test_random();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL queue_drain got=%0d want=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
